handshake_tx_arb: RTL and testbench

//  Source-side 4-phase req/ack handshake engine with CH request channels.

---
 rtl/handshake_tx_arb_if.sv | 33 +++
 rtl/handshake_tx_arb.sv | 142 ++++++++++++++
 tb/tb_handshake_tx_arb.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/handshake_tx_arb_if.sv
// Bundle of the arbitrated source-side req/ack handshake signals.
// No logic, no latency; groups channel requests, the far-side req/ack pair and status outputs.
// Backpressure is carried by sready/sidle per channel and sreq/sack towards the far side.
// Ports: master = engine side (drives sidle/sreq/sdata/schan/done/err/xfer_cnt),
//        slave  = environment side (drives sready/din/sack).
interface handshake_tx_arb_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int CNTW  = 16
);
  localparam int CHW = $clog2(CH);

  logic [CH-1:0]       sready;
  logic [CH*WIDTH-1:0] din;
  logic [CH-1:0]       sidle;
  logic                sreq;
  logic                sack;
  logic [WIDTH-1:0]    sdata;
  logic [CHW-1:0]      schan;
  logic                done;
  logic                err;
  logic [CNTW-1:0]     xfer_cnt;

  modport master (
    input  sready, din, sack,
    output sidle, sreq, sdata, schan, done, err, xfer_cnt
  );

  modport slave (
    output sready, din, sack,
    input  sidle, sreq, sdata, schan, done, err, xfer_cnt
  );
endinterface

// File: rtl/handshake_tx_arb.sv
// Round-robin multi-channel source for a 4-phase req/ack handshake, with ack timeout/abort and transfer count.
// Latency: sready seen at edge N -> sreq high after edge N; done/err are registered 1-cycle pulses.
// Backpressure: a channel holds sready until its sidle falls; no grant while a stale sack is still high.
// Ports: clk, rst (sync, active-high); bus.master: sready/din in, sidle out, sreq out / sack in,
//        sdata/schan (granted word and its channel), done/err pulses, xfer_cnt (completed transfers).
module handshake_tx_arb #(
  parameter int WIDTH   = 8,
  parameter int CH      = 4,
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  handshake_tx_arb_if.master   bus
);
  localparam int CHW = $clog2(CH);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, ACK_HI, WAIT_LO} state_t;

  state_t           state_q, state_d;
  logic             sreq_q, sreq_d;
  logic [WIDTH-1:0] sdata_q, sdata_d;
  logic [CHW-1:0]   schan_q, schan_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [CHW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [TW-1:0]    tcnt_inc;

  logic             gnt_vld;
  logic [CHW-1:0]   gnt;
  logic [CHW:0]     cand;
  logic [CH-1:0]    sidle_w;

  // Round-robin search: first requesting channel at or after ptr, wrapping at CH.
  // cand carries one extra bit so the wrap also works for non-power-of-two CH.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    for (int j = 0; j < CH; j++) begin
      cand = {1'b0, ptr_q} + (CHW+1)'(j);
      if (cand >= (CHW+1)'(CH)) cand = cand - (CHW+1)'(CH);
      if (!gnt_vld && bus.sready[cand[CHW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = cand[CHW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sreq_d   = sreq_q;
    sdata_d  = sdata_q;
    schan_d  = schan_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    tcnt_d   = tcnt_q;
    tcnt_inc = tcnt_q + TW'(1);
    case (state_q)
      IDLE: begin
        // A sack still high from an earlier transfer blocks new grants.
        if (gnt_vld && !bus.sack) begin
          sdata_d = bus.din[int'(gnt)*WIDTH +: WIDTH];
          schan_d = gnt;
          sreq_d  = 1'b1;
          ptr_d   = (gnt == CHW'(CH-1)) ? '0 : gnt + CHW'(1);
          tcnt_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        tcnt_d = tcnt_inc;
        // sack is checked first so an ack in the expiring cycle still completes normally.
        if (bus.sack) begin
          sreq_d  = 1'b0;
          state_d = ACK_HI;
        end else if (tcnt_inc >= TW'(TIMEOUT)) begin
          sreq_d  = 1'b0;
          err_d   = 1'b1;
          state_d = WAIT_LO;
        end
      end
      ACK_HI: begin
        if (!bus.sack) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNTW'(1);
          state_d = IDLE;
        end
      end
      WAIT_LO: begin
        // Abort path: a late ack is simply allowed to fall before going idle.
        if (!bus.sack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreq_q  <= 1'b0;
      sdata_q <= '0;
      schan_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sreq_q  <= sreq_d;
      sdata_q <= sdata_d;
      schan_q <= schan_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Only the channel owning the in-flight transfer sees sidle low.
  always_comb begin
    sidle_w = '1;
    for (int i = 0; i < CH; i++) begin
      if (state_q != IDLE && schan_q == CHW'(i)) sidle_w[i] = 1'b0;
    end
  end

  assign bus.sidle    = sidle_w;
  assign bus.sreq     = sreq_q;
  assign bus.sdata    = sdata_q;
  assign bus.schan    = schan_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.xfer_cnt = cnt_q;
endmodule

// File: tb/tb_handshake_tx_arb.sv
module tb_handshake_tx_arb;
  localparam int WIDTH   = 8;
  localparam int CH      = 4;
  localparam int TIMEOUT = 4;
  localparam int CNTW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  handshake_tx_arb_if #(.WIDTH(WIDTH), .CH(CH), .CNTW(CNTW)) bus ();

  handshake_tx_arb #(.WIDTH(WIDTH), .CH(CH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       is_err;
    logic [1:0] ch;
    logic [7:0] data;
    logic [3:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] din_of(input int c);
    return bus.din[c*8 +: 8];
  endfunction

  // Queue the outcome a transfer on channel c must produce.
  task automatic expect_xfer(input int c, input logic is_err);
    exp_t e;
    if (!is_err) exp_cnt = exp_cnt + 4'd1;
    e.is_err = is_err;
    e.ch     = 2'(c);
    e.data   = din_of(c);
    e.cnt    = exp_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per done/err pulse; while sreq is high checks held word and sidle.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] want_sidle;
    if (rst === 1'b0) begin
      if (bus.done || bus.err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b, required no pulse", bus.done, bus.err);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {30'd0, bus.err, bus.done}, e.is_err ? 32'd2 : 32'd1);
          check("pulse_schan", 32'(bus.schan), 32'(e.ch));
          check("pulse_sdata", 32'(bus.sdata), 32'(e.data));
          check("pulse_xfer_cnt", 32'(bus.xfer_cnt), 32'(e.cnt));
        end
      end
      if (bus.sreq) begin
        want_sidle = ~(4'b0001 << bus.schan);
        check("sidle_owner", 32'(bus.sidle), 32'(want_sidle));
        if (exp_q.size() > 0) begin
          check("sdata_hold", 32'(bus.sdata), 32'(exp_q[0].data));
          check("schan_hold", 32'(bus.schan), 32'(exp_q[0].ch));
        end
      end
    end
  end

  task automatic wait_sreq();
    int n = 0;
    while (!bus.sreq && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.sreq) begin
      checks++;
      errors++;
      $display("FAIL sreq_wait: sreq=0 after %0d cycles, required 1", n);
    end
  endtask

  // Far side: ack ack_dly cycles after first seeing sreq, drop sack drop_dly cycles after sreq falls.
  // hi returns the number of cycles sreq was observed high.
  task automatic far_ack(input int ack_dly, input int drop_dly, input bit drop_rdy,
                         input bit scramble, output int hi);
    int n;
    hi = 0;
    wait_sreq();
    if (!bus.sreq) return;
    hi = 1;
    if (drop_rdy) bus.sready = '0;
    if (scramble) bus.din = ~bus.din;
    for (int k = 0; k < ack_dly; k++) begin
      @(negedge clk);
      if (bus.sreq) hi++;
    end
    bus.sack = 1'b1;
    n = 0;
    while (bus.sreq && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (drop_dly) @(negedge clk);
    bus.sack = 1'b0;
  endtask

  // Far side that never acks; counts sreq-high cycles.
  task automatic far_silent(output int hi);
    int n = 0;
    hi = 0;
    wait_sreq();
    if (!bus.sreq) return;
    bus.sready = '0;
    while (bus.sreq && n < 50) begin
      hi++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    int hi;
    rst        = 1'b1;
    bus.sready = '0;
    bus.din    = '0;
    bus.sack   = 1'b0;
    exp_cnt    = '0;
    repeat (3) @(negedge clk);
    check("rst_sreq", 32'(bus.sreq), 32'd0);
    check("rst_sdata", 32'(bus.sdata), 32'd0);
    check("rst_schan", 32'(bus.schan), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
    check("rst_sidle", 32'(bus.sidle), 32'hF);
    rst = 1'b0;

    // 1: single channel, ack 3 cycles after req, release 3 later; ack lands on the last allowed cycle.
    bus.din    = {8'h44, 8'h33, 8'h22, 8'hA5};
    bus.sready = 4'b0001;
    expect_xfer(0, 1'b0);
    far_ack(3, 3, 1'b1, 1'b0, hi);
    check("t1_sreq_cycles", 32'(hi), 32'd4);
    repeat (3) @(negedge clk);
    check("t1_xfer_cnt", 32'(bus.xfer_cnt), 32'd1);

    // 2: all channels requesting -> 0,1,2,3,0 with words 01,12,23,34,01.
    do_reset();
    bus.din    = {8'h34, 8'h23, 8'h12, 8'h01};
    bus.sready = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      expect_xfer(t % 4, 1'b0);
      far_ack(1, 1, t == 4, 1'b0, hi);
      check("t2_sreq_cycles", 32'(hi), 32'd2);
    end
    repeat (3) @(negedge clk);
    check("t2_xfer_cnt", 32'(bus.xfer_cnt), 32'd5);

    // 3: no ack -> abort after TIMEOUT cycles, count unchanged, next grant still works.
    bus.sready = 4'b0010;
    expect_xfer(1, 1'b1);
    far_silent(hi);
    check("t3_timeout_cycles", 32'(hi), 32'd4);
    repeat (2) @(negedge clk);
    check("t3_xfer_cnt", 32'(bus.xfer_cnt), 32'd5);
    bus.sready = 4'b0100;
    expect_xfer(2, 1'b0);
    far_ack(1, 1, 1'b1, 1'b0, hi);
    check("t3_next_sreq_cycles", 32'(hi), 32'd2);
    // late ack arriving after the abort is ignored
    bus.sready = 4'b1000;
    expect_xfer(3, 1'b1);
    far_ack(4, 3, 1'b1, 1'b0, hi);
    check("t3_late_ack_cycles", 32'(hi), 32'd4);
    repeat (3) @(negedge clk);

    // 4: ack in the expiring cycle wins; din changed after grant must not reach sdata.
    bus.sready = 4'b0001;
    expect_xfer(0, 1'b0);
    far_ack(3, 1, 1'b1, 1'b1, hi);
    check("t4_sreq_cycles", 32'(hi), 32'd4);
    bus.din = {8'h34, 8'h23, 8'h12, 8'h01};
    repeat (3) @(negedge clk);
    check("t4_xfer_cnt", 32'(bus.xfer_cnt), 32'd7);

    // 5: reset mid-REQ with sack stuck high; no grant until sack falls.
    bus.sready = 4'b0100;
    wait_sreq();
    @(negedge clk);
    rst      = 1'b1;
    bus.sack = 1'b1;
    @(negedge clk);
    check("t5_sreq_after_rst", 32'(bus.sreq), 32'd0);
    check("t5_xfer_cnt_rst", 32'(bus.xfer_cnt), 32'd0);
    check("t5_sidle_rst", 32'(bus.sidle), 32'hF);
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_stale_ack_no_grant", 32'(bus.sreq), 32'd0);
    end
    bus.sack = 1'b0;
    expect_xfer(2, 1'b0);
    far_ack(1, 1, 1'b1, 1'b0, hi);
    repeat (3) @(negedge clk);
    check("t5_xfer_cnt", 32'(bus.xfer_cnt), 32'd1);

    // 6: 17 transfers on a 4-bit counter -> wraps 15 -> 0 -> 1.
    do_reset();
    bus.sready = 4'b0001;
    for (int t = 0; t < 17; t++) begin
      expect_xfer(0, 1'b0);
      far_ack(1, 1, t == 16, 1'b0, hi);
    end
    repeat (3) @(negedge clk);
    check("t6_xfer_cnt_wrap", 32'(bus.xfer_cnt), 32'd1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
